sparse_conv_pe: RTL and testbench

Sparse 1-D row-convolution processing element for the object-tracking CNN accelerator. Each start consumes one compressed input-activation (IA) row and one compressed filter row. It multiplies every IA nonzero against every weight nonzero, one pair per cycle. Products that land on the selected output row accumulate into a 32-entry partial-sum buffer, which is exposed continuously on `o_output_feature`.

---
 rtl/sparse_conv_pe.sv | 120 ++++++++++++
 tb/tb_sparse_conv_pe.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sparse_conv_pe.sv
// rtl/sparse_conv_pe.sv - sparse 1-D row-convolution PE, one IA x weight pair per cycle
module sparse_conv_pe #(
  parameter int N_IA  = 32,
  parameter int N_W   = 32,
  parameter int DW    = 16,
  parameter int AW    = 32,
  parameter int Q_MAX = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [8:0]            i_ia_h,
  input  logic [6:0]            i_ia_w,
  input  logic [N_IA*DW-1:0]    i_ia_data,
  input  logic [N_IA*6-1:0]     i_ia_c_idx,
  input  logic [2:0]            i_ia_iters,
  input  logic [5:0]            i_ia_len,
  input  logic [2:0]            i_w_s,
  input  logic [N_W*DW-1:0]     i_w_data,
  input  logic [N_W*3-1:0]      i_w_c_idx,
  input  logic [8:0]            i_pos_ptr,
  input  logic [2:0]            i_r_idx,
  input  logic [5:0]            i_k_idx,
  input  logic [2:0]            i_w_iters,
  input  logic [5:0]            i_w_len,
  output logic                  o_finish,
  output logic [Q_MAX*AW-1:0]   o_output_feature
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e                state_q, state_d;
  logic [5:0]            i_q, i_d, j_q, j_d, k_q;
  logic signed [AW-1:0]  acc_q [Q_MAX];

  logic [5:0]            ia_c;
  logic [2:0]            w_c;
  logic signed [DW-1:0]  ia_v, w_v;
  logic signed [2*DW-1:0] prod;
  logic [6:0]            q_full, span;
  logic [4:0]            q_idx;
  logic                  pair_ok, row_ok, last_i, last_j, clear_acc, empty;

  always_comb begin
    ia_c    = i_ia_c_idx[i_q*6 +: 6];
    w_c     = i_w_c_idx[j_q*3 +: 3];
    ia_v    = i_ia_data[i_q*DW +: DW];
    w_v     = i_w_data[j_q*DW +: DW];
    prod    = ia_v * w_v;
    q_full  = {1'b0, ia_c} - {4'b0, w_c};
    span    = i_ia_w - {4'b0, i_w_s};
    q_idx   = q_full[4:0];
    // span is only meaningful when W >= S, so that term guards the subtraction
    pair_ok = (ia_c >= {3'b0, w_c}) && (i_ia_w >= {4'b0, i_w_s}) &&
              (q_full <= span) && (q_full < 7'd32);
    row_ok  = (i_ia_h >= {6'b0, i_r_idx}) &&
              ((i_ia_h - {6'b0, i_r_idx}) == i_pos_ptr);
    last_i  = (i_q == i_ia_len - 6'd1);
    last_j  = (j_q == i_w_len - 6'd1);
    empty   = (i_ia_len == 6'd0) || (i_w_len == 6'd0);
    clear_acc = ((i_ia_iters == 3'd0) && (i_w_iters == 3'd0)) || (i_k_idx != k_q);
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          i_d     = 6'd0;
          j_d     = 6'd0;
          state_d = (!row_ok || empty) ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_j) begin
          j_d = 6'd0;
          if (last_i) state_d = DONE;
          else        i_d     = i_q + 6'd1;
        end else begin
          j_d = j_q + 6'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign o_finish = (state_q == DONE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      i_q     <= 6'd0;
      j_q     <= 6'd0;
      k_q     <= 6'd0;
      for (int q = 0; q < Q_MAX; q++) acc_q[q] <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      if (state_q == IDLE && i_start) begin
        k_q <= i_k_idx;
        // a new output channel or the first channel iteration starts a fresh sum
        if (clear_acc) begin
          for (int q = 0; q < Q_MAX; q++) acc_q[q] <= '0;
        end
      end
      if (state_q == CALC && pair_ok) begin
        acc_q[q_idx] <= acc_q[q_idx] + AW'(prod);
      end
    end
  end

  for (genvar g = 0; g < Q_MAX; g++) begin : g_out
    assign o_output_feature[g*AW +: AW] = acc_q[g];
  end

endmodule

// File: tb/tb_sparse_conv_pe.sv
// tb/tb_sparse_conv_pe.sv - directed bench for sparse_conv_pe with a pair-enumeration model
module tb_sparse_conv_pe;
  localparam int N_IA = 32, N_W = 32, DW = 16, AW = 32, Q_MAX = 32;

  logic                 clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [8:0]           ia_h, pos;
  logic [6:0]           ia_w;
  logic [N_IA*DW-1:0]   ia_data;
  logic [N_IA*6-1:0]    ia_c;
  logic [2:0]           ia_iters, w_s, r_idx, w_iters;
  logic [5:0]           ia_len, w_len, k_idx;
  logic [N_W*DW-1:0]    w_data;
  logic [N_W*3-1:0]     w_c;
  logic                 fin;
  logic [Q_MAX*AW-1:0]  feat;

  int total = 0, bad = 0;

  sparse_conv_pe #(.N_IA(N_IA), .N_W(N_W), .DW(DW), .AW(AW), .Q_MAX(Q_MAX)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_ia_h(ia_h), .i_ia_w(ia_w), .i_ia_data(ia_data), .i_ia_c_idx(ia_c),
    .i_ia_iters(ia_iters), .i_ia_len(ia_len), .i_w_s(w_s), .i_w_data(w_data),
    .i_w_c_idx(w_c), .i_pos_ptr(pos), .i_r_idx(r_idx), .i_k_idx(k_idx),
    .i_w_iters(w_iters), .i_w_len(w_len), .o_finish(fin), .o_output_feature(feat)
  );

  always #5 clk = ~clk;

  // Model: on an accepted start the whole row product is summed at once;
  // rem counts the cycles still owed before the done pulse.
  logic signed [31:0] macc [32];
  logic [5:0]         mk;
  int                 rem;
  bit                 exp_fin;
  int                 m_pairs, m_c, m_s, m_q;
  logic signed [15:0] m_a, m_b;

  always @(posedge clk) begin
    if (!rst_n) begin
      foreach (macc[q]) macc[q] = 0;
      mk = 0; rem = 0; exp_fin = 0;
    end else if (rem > 0) begin
      rem = rem - 1;
      if (rem == 0) exp_fin = 1;
    end else if (exp_fin) begin
      exp_fin = 0;
    end else if (start) begin
      m_pairs = int'(ia_len) * int'(w_len);
      if ((ia_iters == 0 && w_iters == 0) || k_idx != mk) foreach (macc[q]) macc[q] = 0;
      mk = k_idx;
      if (int'(ia_h) < int'(r_idx) || int'(ia_h) - int'(r_idx) != int'(pos) || m_pairs == 0) begin
        exp_fin = 1;
      end else begin
        rem = m_pairs;
        for (int i = 0; i < int'(ia_len); i++) begin
          for (int j = 0; j < int'(w_len); j++) begin
            m_c = int'(ia_c[i*6 +: 6]);
            m_s = int'(w_c[j*3 +: 3]);
            m_q = m_c - m_s;
            if (m_q >= 0 && ia_w >= 7'(w_s) && m_q <= int'(ia_w) - int'(w_s) && m_q < 32) begin
              m_a = ia_data[i*16 +: 16];
              m_b = w_data[j*16 +: 16];
              macc[m_q] = macc[m_q] + m_a * m_b;
            end
          end
        end
      end
    end
  end

  int mm;
  always @(negedge clk) begin
    total++;
    if (fin !== exp_fin) begin
      bad++;
      $display("FAIL finish act=%0b exp=%0b t=%0t", fin, exp_fin, $time);
    end
    if (rem == 0) begin
      total++;
      mm = -1;
      for (int q = 31; q >= 0; q--) if (feat[q*32 +: 32] !== macc[q]) mm = q;
      if (mm >= 0) begin
        bad++;
        $display("FAIL acc[%0d] act=%0d exp=%0d t=%0t", mm,
                 $signed(feat[mm*32 +: 32]), macc[mm], $time);
      end
    end
  end

  function automatic logic signed [31:0] acc(input int q);
    return feat[q*32 +: 32];
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic clear_rows();
    ia_data = '0; ia_c = '0; w_data = '0; w_c = '0;
  endtask

  task automatic set_ia(input int n, input int c, input int v);
    ia_c[n*6 +: 6] = 6'(c);
    ia_data[n*16 +: 16] = 16'(v);
  endtask

  task automatic set_w(input int n, input int s, input int v);
    w_c[n*3 +: 3] = 3'(s);
    w_data[n*16 +: 16] = 16'(v);
  endtask

  task automatic basic_rows();
    clear_rows();
    set_ia(0, 2, 3); set_ia(1, 4, -2);
    set_w(0, 0, 5);  set_w(1, 2, 7);
    ia_len = 2; w_len = 2;
  endtask

  task automatic run(input int exp_lat, input string nm);
    int lat;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    lat = -1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (fin) begin lat = c; break; end
    end
    chk(nm, lat, exp_lat);
  endtask

  int nf, nz;
  initial begin
    ia_h = 0; pos = 0; r_idx = 0; ia_w = 8; w_s = 3;
    ia_iters = 0; w_iters = 0; k_idx = 1; ia_len = 0; w_len = 0;
    clear_rows();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    nz = 0;
    for (int q = 0; q < 32; q++) if (acc(q) != 0) nz++;
    chk("rst_fin", fin, 0);
    chk("rst_nonzero", nz, 0);

    basic_rows();
    run(4, "basic_lat");
    chk("basic_acc0", acc(0), 21);
    chk("basic_acc2", acc(2), 1);
    chk("basic_acc4", acc(4), -10);
    chk("basic_acc1", acc(1), 0);

    ia_iters = 1;
    run(4, "accum_lat");
    chk("accum_acc0", acc(0), 42);
    chk("accum_acc2", acc(2), 2);
    chk("accum_acc4", acc(4), -20);

    ia_h = 1;
    run(0, "rowmis_lat");
    chk("rowmis_acc0", acc(0), 42);
    ia_h = 0;

    clear_rows(); set_ia(0, 7, 1); set_w(0, 0, 1); ia_len = 1; w_len = 1;
    run(1, "drop_hi_lat");
    chk("drop_hi_acc7", acc(7), 0);
    chk("drop_hi_acc0", acc(0), 42);
    clear_rows(); set_ia(0, 1, 1); set_w(0, 2, 1);
    run(1, "drop_neg_lat");
    chk("drop_neg_acc4", acc(4), -20);

    basic_rows(); k_idx = 2;
    run(4, "newk_lat");
    chk("newk_acc0", acc(0), 21);
    chk("newk_acc4", acc(4), -10);

    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    nf = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (fin) nf++;
      start = (c == 1 || c == 4);
    end
    start = 1'b0;
    chk("busy_finishes", nf, 1);
    chk("busy_acc0", acc(0), 42);

    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    nf = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (fin) nf++;
    end
    chk("rstmid_finishes", nf, 0);
    chk("rstmid_acc0", acc(0), 0);
    chk("rstmid_acc2", acc(2), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
